// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, writeback entry type and ALU opcodes
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]       res;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_en;
  } wb_entry_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry in-order writeback buffer with pointers and count
module wb_fifo2
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_push,
  input  wb_entry_t       i_push_entry,
  input  logic            i_pop,
  output wb_entry_t       o_head,
  output wb_entry_t [1:0] o_entries,
  output logic      [1:0] o_valid,
  output logic            o_head_idx,
  output logic            o_full,
  output logic            o_empty
);

  wb_entry_t [1:0] r_mem;
  logic            r_head;
  logic            r_tail;
  logic [1:0]      r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_tail <= ~r_tail;
      if (i_pop)  r_head <= ~r_head;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset; validity comes from count/head alone.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_push_entry;
  end

  assign o_head     = r_mem[r_head];
  assign o_entries  = r_mem;
  assign o_head_idx = r_head;
  assign o_full     = (r_count == 2'd2);
  assign o_empty    = (r_count == 2'd0);
  assign o_valid[0] = r_count[1] | (r_count[0] & ~r_head);
  assign o_valid[1] = r_count[1] | (r_count[0] &  r_head);

endmodule

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage: buffering, grant-gated retire, forwarding
module alu_wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_alu_res,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wb_en,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic                  rf_grant,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  busy
);

  if (DEPTH != 2 || XLEN != cpu_pkg::XLEN || REG_ADDR_W != cpu_pkg::REG_ADDR_W) begin : g_bad_param
    $error("alu_wb_stage: only DEPTH=2 with package widths is supported");
  end

  wb_entry_t       w_head;
  wb_entry_t [1:0] w_entries;
  wb_entry_t       w_push_entry;
  logic      [1:0] w_valid;
  logic      [1:0] w_match;
  logic            w_head_idx;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_retire;
  logic            w_head_writes;

  assign w_push_entry = '{res: in_alu_res, rd: in_rd, wb_en: in_wb_en};
  assign w_accept     = in_valid && !w_full && !flush;

  // Entries that never touch the register file retire without waiting for the port.
  assign w_head_writes = w_head.wb_en && (w_head.rd != '0);
  assign w_retire      = !w_empty && (rf_grant || !w_head_writes) && !flush;

  wb_fifo2 u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (flush),
    .i_push       (w_accept),
    .i_push_entry (w_push_entry),
    .i_pop        (w_retire),
    .o_head       (w_head),
    .o_entries    (w_entries),
    .o_valid      (w_valid),
    .o_head_idx   (w_head_idx),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  assign in_ready = !w_full;
  assign busy     = !w_empty;
  assign rf_we    = rst_n && !flush && !w_empty && w_head_writes;
  assign rf_waddr = rf_we ? w_head.rd  : '0;
  assign rf_wdata = rf_we ? w_head.res : '0;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_match[i] = w_valid[i] && w_entries[i].wb_en && (w_entries[i].rd == fwd_addr) &&
                   (fwd_addr != '0);
    end
  end

  // With both entries matching the buffer is full, so the younger one sits opposite head.
  always_comb begin
    fwd_data = '0;
    if (w_match[0] && w_match[1]) fwd_data = w_entries[~w_head_idx].res;
    else if (w_match[0])          fwd_data = w_entries[0].res;
    else if (w_match[1])          fwd_data = w_entries[1].res;
  end

  assign fwd_hit = |w_match;

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - randomized and directed bench against a queue reference model
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_res;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_grant;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        busy;

  always #5 clk = ~clk;

  alu_wb_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_res (in_alu_res),
    .in_rd      (in_rd),
    .in_wb_en   (in_wb_en),
    .flush      (flush),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_grant   (rf_grant),
    .fwd_addr   (fwd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit head_writes();
    return (q.size() != 0) && q[0].we && (q[0].rd != 5'd0);
  endfunction

  // Compare every output against the model late in the cycle, then advance the model.
  task automatic cycle();
    logic        exp_we;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    logic        exp_hit;
    logic [31:0] exp_fd;
    bit          acc;
    bit          ret;
    ent_t        e;
    #3;
    exp_we  = rst_n && !flush && head_writes();
    exp_a   = exp_we ? q[0].rd  : 5'd0;
    exp_d   = exp_we ? q[0].res : 32'd0;
    exp_hit = 1'b0;
    exp_fd  = 32'd0;
    if (fwd_addr != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!exp_hit && q[i].we && q[i].rd == fwd_addr) begin
          exp_hit = 1'b1;
          exp_fd  = q[i].res;
        end
      end
    end
    check_eq("in_ready", in_ready, q.size() < 2);
    check_eq("busy",     busy,     q.size() != 0);
    check_eq("rf_we",    rf_we,    exp_we);
    check_eq("rf_waddr", rf_waddr, exp_a);
    check_eq("rf_wdata", rf_wdata, exp_d);
    check_eq("fwd_hit",  fwd_hit,  exp_hit);
    check_eq("fwd_data", fwd_data, exp_fd);
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      ret = (q.size() != 0) && (rf_grant || !head_writes());
      if (ret) void'(q.pop_front());
      if (acc) begin
        e.res = in_alu_res;
        e.rd  = in_rd;
        e.we  = in_wb_en;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] r, input logic [4:0] d,
                     input logic w, input logic g);
    in_valid   = v;
    in_alu_res = r;
    in_rd      = d;
    in_wb_en   = w;
    rf_grant   = g;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_alu_res = '0; in_rd = '0; in_wb_en = 1'b0;
    flush = 1'b0; rf_grant = 1'b0; fwd_addr = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_busy",  busy,     0);
    check_eq("rst_we",    rf_we,    0);
    check_eq("rst_waddr", rf_waddr, 0);
    check_eq("rst_wdata", rf_wdata, 0);
    check_eq("rst_hit",   fwd_hit,  0);

    put(1, 32'h2A, 5, 1, 1);
    check_eq("tp1_we",    rf_we,    1);
    check_eq("tp1_waddr", rf_waddr, 5);
    check_eq("tp1_wdata", rf_wdata, 32'h2A);
    put(0, 0, 0, 0, 1);
    check_eq("tp1_busy",  busy,     0);

    put(1, 32'h101, 1, 1, 0);
    put(1, 32'h102, 2, 1, 0);
    check_eq("tp2_ready", in_ready, 0);
    put(1, 32'h103, 3, 1, 0);
    put(1, 32'h103, 3, 1, 1);
    put(1, 32'h103, 3, 1, 1);
    check_eq("tp2_waddr", rf_waddr, 3);
    put(0, 0, 0, 0, 1);
    put(0, 0, 0, 0, 1);

    fwd_addr = 5'd0;
    put(1, 32'hFFFF_FFFF, 0, 1, 0);
    put(1, 32'h5, 9, 0, 0);
    check_eq("tp3_we", rf_we, 0);
    put(0, 0, 0, 0, 0);
    check_eq("tp3_busy", busy, 0);

    fwd_addr = 5'd7;
    put(1, 32'h11, 7, 1, 0);
    put(1, 32'h22, 7, 1, 0);
    check_eq("tp4_hit2",  fwd_hit,  1);
    check_eq("tp4_data2", fwd_data, 32'h22);
    put(0, 0, 0, 0, 1);
    check_eq("tp4_data1", fwd_data, 32'h22);
    put(0, 0, 0, 0, 1);
    check_eq("tp4_hit0",  fwd_hit,  0);

    put(1, 32'hA, 3, 1, 0);
    put(1, 32'hB, 4, 1, 0);
    flush = 1'b1;
    put(1, 32'hC, 6, 1, 1);
    flush = 1'b0;
    check_eq("tp5_ready", in_ready, 1);
    check_eq("tp5_busy",  busy,     0);
    put(0, 0, 0, 0, 1);

    put(1, 32'hD, 8, 1, 0);
    put(1, 32'hE, 9, 1, 0);
    check_eq("tp6_we_pre", rf_we, 1);
    rst_n = 1'b0;
    put(0, 0, 0, 0, 1);
    rst_n = 1'b1;
    check_eq("tp6_busy",  busy,     0);
    check_eq("tp6_ready", in_ready, 1);
    check_eq("tp6_we",    rf_we,    0);
    check_eq("tp6_waddr", rf_waddr, 0);
    put(0, 0, 0, 0, 1);

    for (int n = 0; n < 500; n++) begin
      rst_n    = ($urandom_range(63) != 0);
      flush    = ($urandom_range(15) == 0);
      fwd_addr = 5'($urandom_range(7));
      put(1'($urandom_range(1)), $urandom, 5'($urandom_range(7)),
          ($urandom_range(3) != 0), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
